md_unit_iter: RTL
=================

// Module: md_unit_iter
// PURPOSE
//  Iterative RV32M multiply/divide execution unit; consumer of the decoder's md_req_* fields for RS_ENT_MUL/RS_ENT_DIV ops.
//  Takes one request per valid/ready handshake, computes 1 bit/cycle (shift-add mul, restoring div on magnitudes), returns 32-bit result + tag.
//  Sits behind the MUL/DIV reservation station; result goes to the common data bus / ROB writeback arbiter.
// PARAMETERS
//  TAG_W   6   width of the rename/ROB tag carried through unchanged
// PORTS
//  clk             in   1             clock, all state on posedge
//  reset           in   1             synchronous, active-high
//  kill            in   1             flush (mispredict): abort current op, synchronous
//  req_valid       in   1             request present
//  req_ready       out  1             unit can accept (state IDLE)
//  req_op          in   MD_OP_WIDTH   MD_OP_MUL / MD_OP_DIV / MD_OP_REM
//  req_in_1_signed in   1             treat in_1 as signed
//  req_in_2_signed in   1             treat in_2 as signed
//  req_out_sel     in   MD_OUT_SEL_WIDTH  MD_OUT_LO / MD_OUT_HI / MD_OUT_REM
//  req_in_1        in   32            rs1 operand
//  req_in_2        in   32            rs2 operand
//  req_tag         in   TAG_W         destination tag
//  resp_valid      out  1             result valid
//  resp_ready      in   1             writeback accepts result
//  resp_result     out  32            result
//  resp_tag        out  TAG_W         tag of the result
// BEHAVIOUR
//  - States: IDLE, BUSY, FIXUP, DONE. reset -> IDLE, resp_valid=0, resp_result=0, resp_tag=0, counter=0.
//  - req_ready = (state==IDLE). Accept = req_valid & req_ready & ~kill; on accept latch op, flags, tag, |in_1|, |in_2|
//    (magnitude only if corresponding signed flag and bit31 set), neg_res flag; -> BUSY, counter=0.
//  - BUSY: one iteration per edge, counter 0..31; after iteration 31 -> FIXUP. Inputs ignored while not IDLE.
//  - MUL: unsigned 32x32 -> 64-bit product; FIXUP negates 64-bit value if signs differ; LO -> [31:0], HI -> [63:32].
//  - DIV/REM: restoring division on magnitudes. Quotient negated if signs differ; remainder takes sign of dividend.
//    Divide by zero: quotient = 32'hFFFF_FFFF (no negate), remainder = in_1 unchanged.
//    Overflow 0x8000_0000 / -1 (signed): quotient 0x8000_0000, remainder 0 (falls out of magnitude algorithm).
//  - FIXUP: one edge; writes resp_result -> DONE, resp_valid=1. Latency: resp_valid first high 33 edges after accepting edge.
//  - DONE: hold resp_result/resp_tag stable while resp_valid & ~resp_ready; on resp_ready -> IDLE, resp_valid=0.
//    No accept in the same cycle as response retirement (req_ready low in DONE).
//  - kill: any state -> IDLE next edge, resp_valid=0; kill beats accept and beats resp handshake in the same cycle.
//  - reset mid-op identical to kill plus clearing result/tag registers.
//  - Counter 5 bits, no wrap beyond 31; op width/encodings from shared MD constants only.
// CONFIGURATION
//  MD_EARLY_OUT_EN defined: on accept, DIV/REM with in_2==0, or MUL with in_1==0 or in_2==0, go IDLE -> FIXUP directly
//    (resp_valid 2 edges after accept); results identical to full path.
//  Undefined: every op takes full 33-edge latency.
// STRUCTURE
//  Shared header: MD_OP_*, MD_OUT_*, MD_OP_WIDTH, MD_OUT_SEL_WIDTH (existing, same as decoder); md_unit_iter state encodings
//    (MD_ST_IDLE/BUSY/FIXUP/DONE, 2 bits).
//  One sub-module: md_cond_neg (parameterised width, out = neg ? -in : in), used for operand magnitude and FIXUP sign correction.
// TESTING
//  MUL 7 x -3, signed/signed, LO -> resp_result 0xFFFF_FFEB, resp_valid exactly 33 edges after accept, tag echoed.
//  MULHU 0xFFFF_FFFF x 0xFFFF_FFFF, HI -> 0xFFFF_FFFE; MULHSU -1 x 0xFFFF_FFFF -> 0xFFFF_FFFF.
//  DIV -7 / 2 -> 0xFFFF_FFFD; REM -7 / 2 -> 0xFFFF_FFFF; DIVU 100 / 0 -> 0xFFFF_FFFF; REMU 100 / 0 -> 100.
//  DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000; REM same operands -> 0.
//  Accept, kill at iteration 10 -> IDLE next edge, no resp_valid; new request next cycle completes correctly.
//  Hold resp_ready=0 for 5 cycles in DONE -> result/tag stable; MD_EARLY_OUT_EN build: DIV x/0 resp_valid 2 edges after accept.

Source files
------------

// File: rtl/md_unit_iter_pkg.sv
// Shared MD operation/output-select encodings (same values as the decoder) and
// the state encodings of the iterative multiply/divide unit.
package md_unit_iter_pkg;

    localparam int unsigned MD_OP_WIDTH      = 2;
    localparam int unsigned MD_OUT_SEL_WIDTH = 2;

    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MUL = 2'd0;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIV = 2'd1;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_REM = 2'd2;

    localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_LO  = 2'd0;
    localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_HI  = 2'd1;
    localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_REM = 2'd2;

    localparam logic [1:0] MD_ST_IDLE  = 2'd0;
    localparam logic [1:0] MD_ST_BUSY  = 2'd1;
    localparam logic [1:0] MD_ST_FIXUP = 2'd2;
    localparam logic [1:0] MD_ST_DONE  = 2'd3;

    // A division-class request returns the remainder rather than the quotient.
    function automatic logic md_sel_rem(input logic [MD_OP_WIDTH-1:0]      op,
                                        input logic [MD_OUT_SEL_WIDTH-1:0] sel);
        return (op == MD_OP_REM) || (sel == MD_OUT_REM);
    endfunction

endpackage

// File: rtl/md_cond_neg.sv
// Conditional two's-complement negation: out_o = neg_i ? -in_i : in_i.
module md_cond_neg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             neg_i,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o
);

    always_comb begin
        out_o = neg_i ? (~in_i + WIDTH'(1)) : in_i;
    end

endmodule

// File: rtl/md_unit_iter.sv
// Iterative RV32M multiply/divide unit: 1 bit per cycle shift-add multiply and
// restoring divide on magnitudes. Optional MD_EARLY_OUT_EN skips trivial zero operands.
module md_unit_iter
    import md_unit_iter_pkg::*;
#(
    parameter int unsigned TAG_W = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        kill,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [MD_OP_WIDTH-1:0]      req_op,
    input  logic                        req_in_1_signed,
    input  logic                        req_in_2_signed,
    input  logic [MD_OUT_SEL_WIDTH-1:0] req_out_sel,
    input  logic [31:0]                 req_in_1,
    input  logic [31:0]                 req_in_2,
    input  logic [TAG_W-1:0]            req_tag,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [31:0]                 resp_result,
    output logic [TAG_W-1:0]            resp_tag
);

    logic [1:0]                  state_q, state_d;
    logic [4:0]                  cnt_q, cnt_d;
    logic [MD_OP_WIDTH-1:0]      op_q, op_d;
    logic [MD_OUT_SEL_WIDTH-1:0] out_sel_q, out_sel_d;
    logic                        neg_res_q, neg_res_d;
    logic                        early_q, early_d;
    logic [31:0]                 b_q, b_d;
    logic [31:0]                 hi_q, hi_d;
    logic [31:0]                 lo_q, lo_d;
    logic                        resp_valid_q, resp_valid_d;
    logic [31:0]                 resp_result_q, resp_result_d;
    logic [TAG_W-1:0]            resp_tag_q, resp_tag_d;

    logic        sign_1, sign_2, in2_zero, accept, req_is_mul;
    logic [31:0] mag_1, mag_2, div_sel, div_fix, fix_result;
    logic [63:0] prod_fix;
    logic [32:0] mul_sum, div_trial;

    assign sign_1     = req_in_1_signed & req_in_1[31];
    assign sign_2     = req_in_2_signed & req_in_2[31];
    assign in2_zero   = (req_in_2 == 32'd0);
    assign req_is_mul = (req_op == MD_OP_MUL);
    assign req_ready  = (state_q == MD_ST_IDLE);
    assign accept     = req_valid & req_ready & ~kill;

    md_cond_neg #(.WIDTH(32)) u_abs_1 (.neg_i(sign_1), .in_i(req_in_1), .out_o(mag_1));
    md_cond_neg #(.WIDTH(32)) u_abs_2 (.neg_i(sign_2), .in_i(req_in_2), .out_o(mag_2));

    // Sign correction: full 64-bit product for MUL, selected quotient/remainder for DIV/REM.
    assign div_sel = md_sel_rem(op_q, out_sel_q) ? hi_q : lo_q;
    md_cond_neg #(.WIDTH(64)) u_fix_mul (.neg_i(neg_res_q), .in_i({hi_q, lo_q}), .out_o(prod_fix));
    md_cond_neg #(.WIDTH(32)) u_fix_div (.neg_i(neg_res_q), .in_i(div_sel), .out_o(div_fix));

    always_comb begin
        if (op_q == MD_OP_MUL) begin
            fix_result = (out_sel_q == MD_OUT_HI) ? prod_fix[63:32] : prod_fix[31:0];
        end else begin
            fix_result = div_fix;
        end
    end

    // Multiply keeps the multiplier in lo and the running sum in hi; divide shifts the
    // dividend out of lo into the partial remainder in hi while quotient bits shift in.
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
    assign div_trial = {hi_q, lo_q[31]} - {1'b0, b_q};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        out_sel_d     = out_sel_q;
        neg_res_d     = neg_res_q;
        early_d       = early_q;
        b_d           = b_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        resp_valid_d  = resp_valid_q;
        resp_result_d = resp_result_q;
        resp_tag_d    = resp_tag_q;

        case (state_q)
            MD_ST_IDLE: begin
                if (accept) begin
                    op_d       = req_op;
                    out_sel_d  = req_out_sel;
                    resp_tag_d = req_tag;
                    cnt_d      = 5'd0;
                    hi_d       = 32'd0;
                    state_d    = MD_ST_BUSY;
                    if (req_is_mul) begin
                        neg_res_d = sign_1 ^ sign_2;
                        b_d       = mag_1;
                        lo_d      = mag_2;
                    end else begin
                        // Divide by zero keeps the all-ones quotient; remainder follows dividend.
                        neg_res_d = md_sel_rem(req_op, req_out_sel) ? sign_1
                                                                    : (sign_1 ^ sign_2) & ~in2_zero;
                        b_d       = mag_2;
                        lo_d      = mag_1;
                    end
`ifdef MD_EARLY_OUT_EN
                    if (req_is_mul && ((req_in_1 == 32'd0) || in2_zero)) begin
                        lo_d    = 32'd0;
                        early_d = 1'b1;
                        state_d = MD_ST_FIXUP;
                    end else if (!req_is_mul && in2_zero) begin
                        hi_d    = mag_1;
                        lo_d    = 32'hFFFF_FFFF;
                        early_d = 1'b1;
                        state_d = MD_ST_FIXUP;
                    end
`endif
                end
            end
            MD_ST_BUSY: begin
                if (op_q == MD_OP_MUL) begin
                    {hi_d, lo_d} = {mul_sum, lo_q[31:1]};
                end else if (!div_trial[32]) begin
                    hi_d = div_trial[31:0];
                    lo_d = {lo_q[30:0], 1'b1};
                end else begin
                    hi_d = {hi_q[30:0], lo_q[31]};
                    lo_d = {lo_q[30:0], 1'b0};
                end
                if (cnt_q == 5'd31) begin
                    state_d = MD_ST_FIXUP;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            MD_ST_FIXUP: begin
                // Early-out requests spend one extra edge here before the result is posted.
                if (early_q) begin
                    early_d = 1'b0;
                end else begin
                    resp_result_d = fix_result;
                    resp_valid_d  = 1'b1;
                    state_d       = MD_ST_DONE;
                end
            end
            MD_ST_DONE: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = MD_ST_IDLE;
                end
            end
            default: state_d = MD_ST_IDLE;
        endcase

        if (kill) begin
            state_d      = MD_ST_IDLE;
            resp_valid_d = 1'b0;
            early_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= MD_ST_IDLE;
            cnt_q         <= 5'd0;
            op_q          <= MD_OP_MUL;
            out_sel_q     <= MD_OUT_LO;
            neg_res_q     <= 1'b0;
            early_q       <= 1'b0;
            b_q           <= 32'd0;
            hi_q          <= 32'd0;
            lo_q          <= 32'd0;
            resp_valid_q  <= 1'b0;
            resp_result_q <= 32'd0;
            resp_tag_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            out_sel_q     <= out_sel_d;
            neg_res_q     <= neg_res_d;
            early_q       <= early_d;
            b_q           <= b_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_tag_q    <= resp_tag_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign resp_tag    = resp_tag_q;

endmodule
